shift_ctrl: RTL and testbench

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl_pkg.sv | 36 +++
 rtl/shift_ctrl_if.sv | 27 ++
 rtl/shift_ctrl_shift.sv | 53 +++++
 rtl/shift_ctrl.sv | 121 ++++++++++++
 tb/tb_shift_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared constants and types for the two-requester shift controller.
// Holds the state encoding, shift-type codes, SIMD lane codes and the long-pass amount.
package shift_ctrl_pkg;

    localparam int SIMD_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] TYPE_SLL = 3'b001;
    localparam logic [2:0] TYPE_SRL = 3'b010;
    localparam logic [2:0] TYPE_SRA = 3'b100;

    localparam logic [1:0] SIMD_CTL_32 = 2'b01;
    localparam logic [1:0] SIMD_CTL_16 = 2'b10;

    // The shift unit handles at most 31 positions per pass, so 32..63 is split 16 + 16 + rest.
    localparam logic [4:0] LONG_PASS_AMT = 5'd16;

    typedef enum logic [1:0] {
        LANE_64 = 2'd0,
        LANE_32 = 2'd1,
        LANE_16 = 2'd2
    } lane_mode_t;

    function automatic lane_mode_t lane_mode(input logic simd_ena, input logic [1:0] simd_ctl);
        if (!simd_ena)                        return LANE_64;
        if ((simd_ctl & SIMD_CTL_32) != 2'b0) return LANE_32;
        if ((simd_ctl & SIMD_CTL_16) != 2'b0) return LANE_16;
        return LANE_64;
    endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Request/result bundle between the requesters/consumer and the shift controller.
interface shift_ctrl_if #(
    parameter int SIMD_DATA_WIDTH = shift_ctrl_pkg::SIMD_DATA_WIDTH
);
    logic [1:0]                      req_valid;
    logic [1:0]                      req_ready;
    logic [1:0][SIMD_DATA_WIDTH-1:0] req_src;
    logic [1:0][5:0]                 req_amt;
    logic [1:0][2:0]                 req_type;
    logic [1:0]                      req_simd_ena;
    logic [1:0][1:0]                 req_simd_ctl;
    logic                            out_valid;
    logic                            out_ready;
    logic [SIMD_DATA_WIDTH-1:0]      out_result;
    logic                            out_id;
    logic                            busy;

    modport master (
        output req_valid, req_src, req_amt, req_type, req_simd_ena, req_simd_ctl, out_ready,
        input  req_ready, out_valid, out_result, out_id, busy
    );

    modport slave (
        input  req_valid, req_src, req_amt, req_type, req_simd_ena, req_simd_ctl, out_ready,
        output req_ready, out_valid, out_result, out_id, busy
    );
endinterface

// File: rtl/shift_ctrl_shift.sv
// Purpose: one combinational shift evaluation (SLL/SRL/SRA) over 64/32/16-bit lanes.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller owns all sequencing.
module shift
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = SIMD_DATA_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic [4:0]       amt,
    input  logic [2:0]       sh_type,
    input  logic             simd_ena,
    input  logic [1:0]       simd_ctl,
    output logic [WIDTH-1:0] result
);

    // Type bits resolve by priority: SLL over SRL over SRA, none gives zero.
    function automatic logic [WIDTH-1:0] shw(input logic [WIDTH-1:0] d, input logic [4:0] a,
                                             input logic [2:0] t);
        if ((t & TYPE_SLL) != 3'b0) return d << a;
        if ((t & TYPE_SRL) != 3'b0) return d >> a;
        if ((t & TYPE_SRA) != 3'b0) return $unsigned($signed(d) >>> a);
        return '0;
    endfunction

    function automatic logic [31:0] sh32(input logic [31:0] d, input logic [4:0] a,
                                         input logic [2:0] t);
        if ((t & TYPE_SLL) != 3'b0) return d << a;
        if ((t & TYPE_SRL) != 3'b0) return d >> a;
        if ((t & TYPE_SRA) != 3'b0) return $unsigned($signed(d) >>> a);
        return '0;
    endfunction

    function automatic logic [15:0] sh16(input logic [15:0] d, input logic [3:0] a,
                                         input logic [2:0] t);
        if ((t & TYPE_SLL) != 3'b0) return d << a;
        if ((t & TYPE_SRL) != 3'b0) return d >> a;
        if ((t & TYPE_SRA) != 3'b0) return $unsigned($signed(d) >>> a);
        return '0;
    endfunction

    always_comb begin
        result = '0;
        case (lane_mode(simd_ena, simd_ctl))
            LANE_32: for (int l = 0; l < WIDTH / 32; l++)
                         result[l*32 +: 32] = sh32(data[l*32 +: 32], amt, sh_type);
            LANE_16: for (int l = 0; l < WIDTH / 16; l++)
                         result[l*16 +: 16] = sh16(data[l*16 +: 16], amt[3:0], sh_type);
            default: result = shw(data, amt, sh_type);
        endcase
    end

endmodule

// File: rtl/shift_ctrl.sv
// Purpose: round-robin arbiter for two shift requesters, iterating one shift unit over 1-3 passes.
// Latency: result valid n+1 cycles after accept (n = 1, 2 or 3 passes).
// Backpressure: result held in DONE until out_ready; no requests accepted while busy.
module shift_ctrl #(
    parameter int SIMD_DATA_WIDTH = shift_ctrl_pkg::SIMD_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    shift_ctrl_if.slave  bus
);
    import shift_ctrl_pkg::*;

    state_t                     state, state_nxt;
    logic                       prio;
    logic [1:0]                 pass_cnt;
    logic [4:0]                 pass_amt;
    logic                       pass_last;
    logic [1:0]                 grant;
    logic                       accept;
    logic                       win_id;
    logic [SIMD_DATA_WIDTH-1:0] work_dat;
    logic [SIMD_DATA_WIDTH-1:0] shift_res;
    logic [5:0]                 work_amt;
    logic [2:0]                 work_type;
    logic                       work_simd_ena;
    logic [1:0]                 work_simd_ctl;
    logic                       work_id;

    always_comb begin
        grant = bus.req_valid;
        if (&bus.req_valid) grant = prio ? 2'b10 : 2'b01;
    end

    // Gated by rst so no grant is visible while the block is held in reset.
    assign bus.req_ready = (state == ST_IDLE && !rst) ? grant : 2'b00;
    assign accept        = |(bus.req_valid & bus.req_ready);
    assign win_id        = bus.req_ready[1];
    assign bus.busy      = (state != ST_IDLE);

    always_comb begin
        pass_amt  = work_amt[4:0];
        pass_last = 1'b1;
        case (lane_mode(work_simd_ena, work_simd_ctl))
            LANE_16: pass_amt = {1'b0, work_amt[3:0]};
            LANE_32: pass_amt = work_amt[4:0];
            default: if (work_amt[5]) begin
                pass_amt  = (pass_cnt == 2'd2) ? work_amt[4:0] : LONG_PASS_AMT;
                pass_last = (pass_cnt == 2'd2) || (pass_cnt == 2'd1 && work_amt[4:0] == 5'd0);
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)                         state_nxt = ST_PASS;
            ST_PASS: if (pass_last)                      state_nxt = ST_DONE;
            ST_DONE: if (bus.out_valid && bus.out_ready) state_nxt = ST_IDLE;
            default:                                     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio           <= 1'b0;
            pass_cnt       <= 2'd0;
            work_dat       <= '0;
            work_amt       <= '0;
            work_type      <= '0;
            work_simd_ena  <= 1'b0;
            work_simd_ctl  <= '0;
            work_id        <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_id     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    work_dat      <= bus.req_src[win_id];
                    work_amt      <= bus.req_amt[win_id];
                    work_type     <= bus.req_type[win_id];
                    work_simd_ena <= bus.req_simd_ena[win_id];
                    work_simd_ctl <= bus.req_simd_ctl[win_id];
                    work_id       <= win_id;
                    prio          <= ~win_id;
                    pass_cnt      <= 2'd0;
                end
                ST_PASS: begin
                    work_dat <= shift_res;
                    pass_cnt <= pass_cnt + 2'd1;
                end
                ST_DONE: begin
                    // First DONE cycle registers the result; it then holds until taken.
                    if (!bus.out_valid) begin
                        bus.out_valid  <= 1'b1;
                        bus.out_result <= work_dat;
                        bus.out_id     <= work_id;
                    end else if (bus.out_ready) begin
                        bus.out_valid  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    shift #(.WIDTH(SIMD_DATA_WIDTH)) u_shift (
        .data     (work_dat),
        .amt      (pass_amt),
        .sh_type  (work_type),
        .simd_ena (work_simd_ena),
        .simd_ctl (work_simd_ctl),
        .result   (shift_res)
    );

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: per-cycle reference model check plus directed literal vectors.
module tb_shift_ctrl;
    import shift_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_ctrl_if #(.SIMD_DATA_WIDTH(64)) bus();
    shift_ctrl #(.SIMD_DATA_WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out (t=%0t)", name, $time);
    endtask

    // Reference: one shift of each lane by the full (lane-masked) amount.
    function automatic logic [63:0] lane_op(input logic [63:0] v, input int w, input int a,
                                            input logic [2:0] t);
        logic [63:0] mask, r;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        v = v & mask;
        if (t[0])      r = (v << a) & mask;
        else if (t[1]) r = v >> a;
        else if (t[2]) begin
            r = v >> a;
            if (v[w-1]) r = r | (mask & ~(mask >> a));
        end else       r = 64'd0;
        return r;
    endfunction

    function automatic logic [63:0] model_result(input logic [63:0] src, input logic [5:0] amt,
                                                 input logic [2:0] t, input logic ena,
                                                 input logic [1:0] ctl);
        int w, a;
        logic [63:0] r;
        if (ena && ctl[0])      begin w = 32; a = int'(amt[4:0]); end
        else if (ena && ctl[1]) begin w = 16; a = int'(amt[3:0]); end
        else                    begin w = 64; a = int'(amt);      end
        r = 64'd0;
        for (int l = 0; l < 64 / w; l++) r = r | (lane_op(src >> (l * w), w, a, t) << (l * w));
        return r;
    endfunction

    function automatic int model_passes(input logic [5:0] amt, input logic ena, input logic [1:0] ctl);
        if (ena && (ctl[0] || ctl[1])) return 1;
        if (!amt[5]) return 1;
        return (amt[4:0] != 5'd0) ? 3 : 2;
    endfunction

    bit          m_busy = 1'b0;
    bit          m_ptr  = 1'b0;
    int          m_acc  = 0;
    int          m_lat  = 0;
    logic [63:0] m_res  = '0;
    logic        m_id   = 1'b0;

    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        bit         exp_vld;
        int         wi;
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 1'b0;
            chk("rst_busy",       64'(bus.busy),      64'd0);
            chk("rst_out_valid",  64'(bus.out_valid), 64'd0);
            chk("rst_req_ready",  64'(bus.req_ready), 64'd0);
            chk("rst_out_result", bus.out_result,     64'd0);
            chk("rst_out_id",     64'(bus.out_id),    64'd0);
        end else begin
            exp_vld = m_busy && (cyc >= m_acc + m_lat);
            chk("busy",      64'(bus.busy),      64'(m_busy));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_vld));
            if (exp_vld) begin
                chk("out_result", bus.out_result,  m_res);
                chk("out_id",     64'(bus.out_id), 64'(m_id));
            end
            exp_rdy = 2'b00;
            if (!m_busy) begin
                exp_rdy = bus.req_valid;
                if (bus.req_valid == 2'b11) exp_rdy = m_ptr ? 2'b10 : 2'b01;
            end
            chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            if (exp_vld && bus.out_ready) begin
                m_busy = 1'b0;
            end else if (!m_busy && exp_rdy != 2'b00) begin
                wi     = exp_rdy[1] ? 1 : 0;
                m_busy = 1'b1;
                m_acc  = cyc + 1;
                m_id   = exp_rdy[1];
                m_ptr  = ~exp_rdy[1];
                m_res  = model_result(bus.req_src[wi], bus.req_amt[wi], bus.req_type[wi],
                                      bus.req_simd_ena[wi], bus.req_simd_ctl[wi]);
                m_lat  = model_passes(bus.req_amt[wi], bus.req_simd_ena[wi], bus.req_simd_ctl[wi]) + 1;
            end
        end
    end

    task automatic set_req(input int id, input logic [63:0] src, input logic [5:0] amt,
                           input logic [2:0] t, input logic ena, input logic [1:0] ctl);
        bus.req_src[id]      = src;
        bus.req_amt[id]      = amt;
        bus.req_type[id]     = t;
        bus.req_simd_ena[id] = ena;
        bus.req_simd_ctl[id] = ctl;
    endtask

    // Waits for any grant, checks the grant vector, returns the accept edge index.
    task automatic wait_grant(input string name, input logic [1:0] exp_vec, output int acc);
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                chk(name, 64'(bus.req_ready), 64'(exp_vec));
                acc = cyc + 1;
                break;
            end
        end
        if (acc < 0) timeout(name);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string name, input logic [63:0] exp_res, input logic exp_id,
                               input int exp_lat, input int acc);
        int got;
        got = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = cyc;
                break;
            end
        end
        if (got < 0) timeout({name, "_valid"});
        else begin
            chk({name, "_result"},  bus.out_result,  exp_res);
            chk({name, "_id"},      64'(bus.out_id), 64'(exp_id));
            chk({name, "_latency"}, 64'(got - acc),  64'(exp_lat));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string name, input int id, input logic [63:0] src, input logic [5:0] amt,
                       input logic [2:0] t, input logic ena, input logic [1:0] ctl,
                       input logic [63:0] exp_res, input int exp_lat);
        int acc;
        set_req(id, src, amt, t, ena, ctl);
        bus.req_valid[id] = 1'b1;
        wait_grant({name, "_grant"}, (id == 1) ? 2'b10 : 2'b01, acc);
        bus.req_valid[id] = 1'b0;
        wait_result(name, exp_res, id[0], exp_lat, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        bit seen;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_src   = '0;
        bus.req_amt   = '0;
        bus.req_type  = '0;
        bus.req_simd_ena = '0;
        bus.req_simd_ctl = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Simultaneous requests with a stalled consumer: req0 first, result held, then req1.
        bus.out_ready = 1'b0;
        set_req(0, 64'h0000_0000_0000_00AB, 6'd8, TYPE_SLL, 1'b0, 2'b00);
        set_req(1, 64'hFFFF_FFFF_FFFF_FF00, 6'd4, TYPE_SRA, 1'b0, 2'b00);
        bus.req_valid = 2'b11;
        wait_grant("arb_first", 2'b01, acc);
        bus.req_valid[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        if (!seen) timeout("stall_valid");
        chk("stall_latency", 64'(cyc - acc), 64'd2);
        for (int k = 0; k < 5; k++) begin
            chk("stall_out_valid",  64'(bus.out_valid), 64'd1);
            chk("stall_out_result", bus.out_result,     64'h0000_0000_0000_AB00);
            chk("stall_out_id",     64'(bus.out_id),    64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        run("arb_second", 1, 64'hFFFF_FFFF_FFFF_FF00, 6'd4, TYPE_SRA, 1'b0, 2'b00,
            64'hFFFF_FFFF_FFFF_FFF0, 2);

        run("sll40",      0, 64'h0000_0000_0000_0001, 6'd40, TYPE_SLL, 1'b0, 2'b00, 64'h0000_0100_0000_0000, 4);
        run("sra63",      1, 64'h8000_0000_0000_0000, 6'd63, TYPE_SRA, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 4);
        run("srl32",      0, 64'hFFFF_FFFF_0000_0000, 6'd32, TYPE_SRL, 1'b0, 2'b00, 64'h0000_0000_FFFF_FFFF, 3);
        run("simd16_sll", 0, 64'h0001_0001_0001_0001, 6'd19, TYPE_SLL, 1'b1, 2'b10, 64'h0008_0008_0008_0008, 2);
        run("simd32_sra", 1, 64'h8000_0000_4000_0000, 6'd4,  TYPE_SRA, 1'b1, 2'b01, 64'hF800_0000_0400_0000, 2);
        run("sra33",      0, 64'h8000_0000_0000_0000, 6'd33, TYPE_SRA, 1'b0, 2'b00, 64'hFFFF_FFFF_C000_0000, 4);
        run("sll48",      1, 64'h0000_0000_0000_FFFF, 6'd48, TYPE_SLL, 1'b0, 2'b00, 64'hFFFF_0000_0000_0000, 4);
        run("sll0",       0, 64'h0000_0000_0000_1234, 6'd0,  TYPE_SLL, 1'b0, 2'b00, 64'h0000_0000_0000_1234, 2);
        run("type_zero",  1, 64'h0000_0000_0000_FFFF, 6'd5,  3'b000,   1'b0, 2'b00, 64'h0000_0000_0000_0000, 2);
        run("type_110",   0, 64'h0000_0000_0000_00F0, 6'd4,  3'b110,   1'b0, 2'b00, 64'h0000_0000_0000_000F, 2);

        // Reset in the middle of a multi-pass operation.
        set_req(0, 64'h0000_0000_0000_0001, 6'd40, TYPE_SLL, 1'b0, 2'b00);
        bus.req_valid[0] = 1'b1;
        wait_grant("midrst_grant", 2'b01, acc);
        bus.req_valid[0] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy",      64'(bus.busy),      64'd0);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_req(0, 64'h0000_0000_0000_0003, 6'd1, TYPE_SLL, 1'b0, 2'b00);
        set_req(1, 64'h0000_0000_0000_0100, 6'd4, TYPE_SRL, 1'b0, 2'b00);
        bus.req_valid = 2'b11;
        wait_grant("postrst_arb", 2'b01, acc);
        bus.req_valid[0] = 1'b0;
        wait_result("postrst_r0", 64'h0000_0000_0000_0006, 1'b0, 2, acc);
        run("postrst_r1", 1, 64'h0000_0000_0000_0100, 6'd4, TYPE_SRL, 1'b0, 2'b00, 64'h0000_0000_0000_0010, 2);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
